// File: rtl/layer7_pkg.sv
// Shared definitions for the layer-7 fully-connected engine.
// Holds the map geometry, lane and accumulator widths, the FSM state type
// and the output saturation helper used by layer7_fc_engine.
package layer7_pkg;

    localparam int unsigned MAP_W     = 5;
    localparam int unsigned POSITIONS = MAP_W * MAP_W;
    localparam int unsigned CH        = 8;
    localparam int unsigned DW        = 16;
    localparam int unsigned VW        = CH * DW;
    localparam int unsigned ACCW      = 40;
    localparam int unsigned FRAC      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        OUT
    } state_t;

    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

    // Clamp an accumulator-width value to the signed 16-bit range.
    function automatic logic signed [15:0] saturate16(input logic signed [ACCW-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/layer7_fc_engine_if.sv
// Bus bundle between the layer-7 engine and its environment.
// Carries the layer-6 memory read port (row/col address, read signal, data),
// the weight ROM port (address, data) and the result valid/ready handshake.
// master: engine side. slave: memory / consumer side.
interface layer7_fc_engine_if #(
    parameter int unsigned VW = layer7_pkg::VW
);
    logic [15:0]   read_row_addr;
    logic [15:0]   read_col_addr;
    logic          layer6_result_read_signal;
    logic [VW-1:0] layer6_result_output;
    logic [7:0]    weight_addr;
    logic [VW-1:0] weight_data;
    logic [15:0]   result_data;
    logic [3:0]    result_index;
    logic          result_valid;
    logic          result_ready;

    modport master (
        output read_row_addr, read_col_addr, layer6_result_read_signal,
        output weight_addr,
        output result_data, result_index, result_valid,
        input  layer6_result_output, weight_data, result_ready
    );

    modport slave (
        input  read_row_addr, read_col_addr, layer6_result_read_signal,
        input  weight_addr,
        input  result_data, result_index, result_valid,
        output layer6_result_output, weight_data, result_ready
    );
endinterface

// File: rtl/layer7_dot_lane_sum.sv
// Combinational CH-lane signed dot product.
// Ports: a, b - packed CH x DW signed lane vectors; sum - ACCW-wide signed
// sum of the CH lane products (each product sign-extended before adding).
module layer7_dot_lane_sum
    import layer7_pkg::*;
(
    input  logic [VW-1:0]          a,
    input  logic [VW-1:0]          b,
    output logic signed [ACCW-1:0] sum
);

    logic signed [DW-1:0]   av;
    logic signed [DW-1:0]   bv;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        sum  = '0;
        av   = '0;
        bv   = '0;
        prod = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            av   = a[i*DW +: DW];
            bv   = b[i*DW +: DW];
            prod = (2*DW)'(av) * (2*DW)'(bv);
            sum  = sum + ACCW'(prod);
        end
    end

endmodule

// File: rtl/layer7_fc_engine.sv
// Layer-7 fully-connected engine.
// Scans the 5x5 layer-6 result map row-major, multiplies each CH-lane vector
// by the matching weight vector, accumulates 25 positions per neuron and
// emits one saturated fixed-point result per neuron over valid/ready.
// Ports: clk, rst (async, active-high), start (run pulse), busy, done
// (one-cycle pulse after the last result is accepted), bus (master side of
// layer7_fc_engine_if: memory read port, weight port, result handshake).
// Optional macro LAYER7_RELU_EN: clamp negative results to zero.
module layer7_fc_engine
    import layer7_pkg::*;
#(
    parameter int unsigned NEURONS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    layer7_fc_engine_if.master        bus
);

    state_t                 state_q, state_d;
    logic [3:0]             neuron_q, neuron_d;
    logic [4:0]             pos_q, pos_d;
    logic [2:0]             row_q, row_d;
    logic [2:0]             col_q, col_d;
    logic                   rd_q, rd_d;
    logic [7:0]             waddr_q, waddr_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] psum_q, psum_d;
    logic [15:0]            res_q, res_d;
    logic [3:0]             idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic signed [ACCW-1:0] lane_sum;
    logic signed [ACCW-1:0] acc_final;
    logic signed [15:0]     res_sat;
    logic [7:0]             next_base;

    layer7_dot_lane_sum u_dot (
        .a   (bus.layer6_result_output),
        .b   (bus.weight_data),
        .sum (lane_sum)
    );

    always_comb begin
        state_d   = state_q;
        neuron_d  = neuron_q;
        pos_d     = pos_q;
        row_d     = row_q;
        col_d     = col_q;
        rd_d      = rd_q;
        waddr_d   = waddr_q;
        acc_d     = acc_q;
        psum_d    = psum_q;
        res_d     = res_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        // psum_q lags the read by one cycle, so the final sum must fold it in
        acc_final = acc_q + psum_q;
        res_sat   = saturate16(acc_final >>> FRAC);
        next_base = 8'((32'(neuron_q) + 32'd1) * POSITIONS);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    neuron_d = '0;
                    pos_d    = '0;
                    row_d    = '0;
                    col_d    = '0;
                    rd_d     = 1'b1;
                    waddr_d  = '0;
                    acc_d    = '0;
                    psum_d   = '0;
                end
            end
            SCAN: begin
                psum_d = lane_sum;
                acc_d  = acc_final;
                if (pos_q == 5'(POSITIONS - 1)) begin
                    state_d = FLUSH;
                    pos_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    rd_d    = 1'b0;
                    waddr_d = '0;
                end else begin
                    pos_d   = pos_q + 5'd1;
                    waddr_d = waddr_q + 8'd1;
                    if (col_q == 3'(MAP_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            FLUSH: begin
                acc_d   = acc_final;
                psum_d  = '0;
`ifdef LAYER7_RELU_EN
                res_d   = res_sat[15] ? '0 : res_sat;
`else
                res_d   = res_sat;
`endif
                idx_d   = neuron_q;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (bus.result_ready) begin
                    valid_d = 1'b0;
                    if (neuron_q == 4'(NEURONS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        neuron_d = neuron_q + 4'd1;
                        pos_d    = '0;
                        row_d    = '0;
                        col_d    = '0;
                        rd_d     = 1'b1;
                        waddr_d  = next_base;
                        acc_d    = '0;
                        psum_d   = '0;
                        state_d  = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            neuron_q <= '0;
            pos_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rd_q     <= 1'b0;
            waddr_q  <= '0;
            acc_q    <= '0;
            psum_q   <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            neuron_q <= neuron_d;
            pos_q    <= pos_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rd_q     <= rd_d;
            waddr_q  <= waddr_d;
            acc_q    <= acc_d;
            psum_q   <= psum_d;
            res_q    <= res_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy                          = busy_q;
    assign done                          = done_q;
    assign bus.read_row_addr             = {13'd0, row_q};
    assign bus.read_col_addr             = {13'd0, col_q};
    assign bus.layer6_result_read_signal = rd_q;
    assign bus.weight_addr               = waddr_q;
    assign bus.result_data               = res_q;
    assign bus.result_index              = idx_q;
    assign bus.result_valid              = valid_q;

endmodule

// File: tb/tb_layer7_fc_engine.sv
module tb_layer7_fc_engine;
    import layer7_pkg::*;

    localparam int NN  = 10;
    localparam int NP  = 25;
    localparam int NCH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    layer7_fc_engine_if bus ();

    layer7_fc_engine #(.NEURONS(NN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [15:0] mem  [NP][NCH];
    logic signed [15:0] wmem [NN*NP][NCH];

    int tests = 0;
    int failed = 0;
    int mon_neuron = 0;
    int mon_k = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Combinational memory and weight ROM models
    always_comb begin
        int r, c;
        bus.layer6_result_output = '0;
        bus.weight_data = '0;
        r = int'(bus.read_row_addr);
        c = int'(bus.read_col_addr);
        if (r < 5 && c < 5) begin
            for (int l = 0; l < NCH; l++) bus.layer6_result_output[l*16 +: 16] = mem[r*5+c][l];
        end
        if (int'(bus.weight_addr) < NN*NP) begin
            for (int l = 0; l < NCH; l++) bus.weight_data[l*16 +: 16] = wmem[bus.weight_addr][l];
        end
    end

    // Address discipline and done-pulse monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.layer6_result_read_signal) begin
                chk("row", bus.read_row_addr, mon_k / 5);
                chk("col", bus.read_col_addr, mon_k % 5);
                chk("waddr", bus.weight_addr, mon_neuron * 25 + mon_k);
                mon_k++;
            end else begin
                chk("idle_addr", {bus.read_row_addr, bus.read_col_addr, bus.weight_addr}, 0);
            end
            if (bus.result_valid && bus.result_ready) begin
                mon_neuron++;
                mon_k = 0;
            end
            if (done) done_cnt++;
        end
    end

    function automatic longint expected(input int n);
        longint acc, sh;
        acc = 0;
        for (int p = 0; p < NP; p++)
            for (int l = 0; l < NCH; l++)
                acc += longint'(mem[p][l]) * longint'(wmem[n*NP+p][l]);
        acc = (acc <<< 24) >>> 24;  // 40-bit wrap
        sh = acc >>> 8;
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
`ifdef LAYER7_RELU_EN
        if (sh < 0) sh = 0;
`endif
        return sh;
    endfunction

    task automatic fill(input int mode);
        for (int p = 0; p < NP; p++)
            for (int l = 0; l < NCH; l++) begin
                case (mode)
                    0: mem[p][l] = 16'sd1;
                    1: mem[p][l] = (l == 0) ? 16'sd256 : 16'sd0;
                    2, 3: mem[p][l] = 16'sd32767;
                    4: mem[p][l] = 16'($urandom_range(1023) - 512);
                    default: mem[p][l] = 16'($urandom);
                endcase
            end
        for (int a = 0; a < NN*NP; a++)
            for (int l = 0; l < NCH; l++) begin
                case (mode)
                    0: wmem[a][l] = 16'sd1;
                    1: wmem[a][l] = (l == 0) ? 16'sd256 : 16'sd0;
                    2: wmem[a][l] = 16'sd32767;
                    3: wmem[a][l] = -16'sd32767;
                    4: wmem[a][l] = 16'($urandom_range(1023) - 512);
                    default: wmem[a][l] = 16'($urandom);
                endcase
            end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input string name, input int stall_n);
        int cyc, base;
        logic [15:0] d0;
        logic [3:0] i0;
        mon_neuron = 0;
        mon_k = 0;
        base = done_cnt;
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        for (int n = 0; n < NN; n++) begin
            if (n == stall_n) bus.result_ready = 1'b0;
            cyc = 0;
            while (!bus.result_valid && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (!bus.result_valid) begin
                chk({name, "_valid_timeout"}, 0, 1);
                return;
            end
            chk({name, "_latency"}, cyc, 26);
            chk({name, "_rd_cycles"}, mon_k, 25);
            chk({name, "_index"}, bus.result_index, n);
            chk({name, "_data"}, $signed(bus.result_data), expected(n));
            if (n == stall_n) begin
                d0 = bus.result_data;
                i0 = bus.result_index;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk({name, "_stall_valid"}, bus.result_valid, 1);
                    chk({name, "_stall_data"}, bus.result_data, d0);
                    chk({name, "_stall_index"}, bus.result_index, i0);
                end
                bus.result_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (n < NN - 1) chk({name, "_valid_drop"}, bus.result_valid, 0);
        end
        chk({name, "_done_high"}, done, 1);
        chk({name, "_busy_low"}, busy, 0);
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_done_count"}, done_cnt - base, 1);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_valid"}, bus.result_valid, 0);
        chk({name, "_rd"}, bus.layer6_result_read_signal, 0);
        chk({name, "_addr"}, {bus.read_row_addr, bus.read_col_addr, bus.weight_addr}, 0);
        chk({name, "_data"}, {bus.result_data, bus.result_index}, 0);
    endtask

    initial begin
        int cyc, base;
        bus.result_ready = 1'b0;
        fill(0);
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;

        fill(0); run("ones", -1);
        fill(1); run("lane0", -1);
        fill(2); run("satpos", -1);
        fill(3); run("satneg", -1);
        fill(4); run("rand_small_stall", 3);
        fill(5); run("rand_full", -1);
        fill(4); run("rand_small", -1);

        // Mid-run start is ignored, then reset aborts the scan
        fill(4);
        mon_neuron = 0;
        mon_k = 0;
        base = done_cnt;
        bus.result_ready = 1'b1;
        pulse_start();
        cyc = 0;
        while (mon_k < 5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        pulse_start();
        cyc = 0;
        while (mon_k < 12 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("mid_reach_pos12", mon_k, 12);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #2;
        check_quiet("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("after_rst");
        chk("midrst_no_done", done_cnt - base, 0);

        run("post_rst", 7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
